bit_deframer: RTL



---
 rtl/bit_deframer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bit_deframer.sv
// bit_deframer: recovers word framing from a 1-bit stream.
// Hunts for SYNC_WORD at any bit alignment, then emits FRAME_LEN data words
// per frame. A flywheel re-checks the sync word at each frame boundary and
// drops lock after MISS_MAX consecutive misses.
// Optional build macro: BIT_DEFRAMER_MSB_FIRST_EN selects MSB-first bit order
// (default is LSB-first).
module bit_deframer #(
   parameter int                WORD_W    = 8,
   parameter logic [WORD_W-1:0] SYNC_WORD = 8'hA5,
   parameter int                FRAME_LEN = 4,
   parameter int                MISS_MAX  = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              DIN,
   input  logic              DIN_DV,
   output logic [WORD_W-1:0] DOUT,
   output logic              DOUT_DV,
   output logic              SOF,
   output logic              LOCKED,
   output logic              SYNC_LOST
);

   // Counter widths: each counter is just wide enough for its largest value.
   localparam int FILL_W = ($clog2(WORD_W + 1) > 1) ? $clog2(WORD_W + 1) : 1;
   localparam int BIT_W  = ($clog2(WORD_W) > 1) ? $clog2(WORD_W) : 1;
   localparam int WCNT_W = ($clog2(FRAME_LEN) > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int MISS_W = ($clog2(MISS_MAX) > 1) ? $clog2(MISS_MAX) : 1;

   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WORD_W);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WORD_W - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
   localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(FRAME_LEN - 1);
   localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);

   localparam logic [1:0] ST_HUNT  = 2'd0;
   localparam logic [1:0] ST_DATA  = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;

   logic [1:0]        state;
   // Only WORD_W-1 history bits are stored; the incoming bit completes the word.
   logic [WORD_W-2:0] sr;
   logic [WORD_W-1:0] sr_next;
   logic [FILL_W-1:0] fill_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [WCNT_W-1:0] word_cnt;
   logic [MISS_W-1:0] miss_cnt;

   // Shift register view including the bit currently on DIN.
`ifdef BIT_DEFRAMER_MSB_FIRST_EN
   assign sr_next = {sr, DIN};
`else
   assign sr_next = {DIN, sr};
`endif

   assign LOCKED = (state != ST_HUNT);

   // Framing state machine; everything advances only on valid bits.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ST_HUNT;
         sr        <= '0;
         fill_cnt  <= '0;
         bit_cnt   <= '0;
         word_cnt  <= '0;
         miss_cnt  <= '0;
         DOUT      <= '0;
         DOUT_DV   <= 1'b0;
         SOF       <= 1'b0;
         SYNC_LOST <= 1'b0;
      end else begin
         DOUT_DV   <= 1'b0;
         SOF       <= 1'b0;
         SYNC_LOST <= 1'b0;
         if (DIN_DV) begin
`ifdef BIT_DEFRAMER_MSB_FIRST_EN
            sr <= sr_next[WORD_W-2:0];
`else
            sr <= sr_next[WORD_W-1:1];
`endif
            case (state)
               ST_HUNT: begin
                  if (fill_cnt < FILL_FULL) begin
                     fill_cnt <= fill_cnt + 1'b1;
                  end
                  if ((fill_cnt >= FILL_LAST) && (sr_next == SYNC_WORD)) begin
                     state    <= ST_DATA;
                     bit_cnt  <= '0;
                     word_cnt <= '0;
                  end
               end
               ST_DATA: begin
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     DOUT    <= sr_next;
                     DOUT_DV <= 1'b1;
                     SOF     <= (word_cnt == '0);
                     if (word_cnt == WORD_LAST) begin
                        word_cnt <= '0;
                        state    <= ST_CHECK;
                     end else begin
                        word_cnt <= word_cnt + 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               ST_CHECK: begin
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     if (sr_next == SYNC_WORD) begin
                        miss_cnt <= '0;
                        state    <= ST_DATA;
                     end else if (miss_cnt < MISS_LAST) begin
                        miss_cnt <= miss_cnt + 1'b1;
                        state    <= ST_DATA;
                     end else begin
                        miss_cnt  <= '0;
                        fill_cnt  <= '0;
                        state     <= ST_HUNT;
                        SYNC_LOST <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               default: begin
                  state <= ST_HUNT;
               end
            endcase
         end
      end
   end

endmodule
